// File: rtl/alu4_pkg.sv
// -----------------------------------------------------------------------------
// alu4_pkg
// Shared types for the 4-bit ALU issue path.
//   ALU_DATA_W : operand/result width of the ALU
//   alu_op_t   : ALU operation encoding
//   alu_cmd_t  : one queued command {operand_A, operand_B, operation}
// -----------------------------------------------------------------------------
package alu4_pkg;

    localparam int ALU_DATA_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] operand_A;
        logic [ALU_DATA_W-1:0] operand_B;
        alu_op_t               operation;
    } alu_cmd_t;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu4_cmd_fifo
// DEPTH-entry command FIFO. Full/empty are derived from the occupancy counter,
// pointers wrap modulo DEPTH. The head entry is read straight from storage.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_cmd     write request and command (caller guarantees !full)
//   i_pop             read request (caller guarantees !empty)
//   o_head            entry at the read pointer (undefined contents when empty)
//   o_full, o_empty   occupancy flags
//   o_level           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu4_cmd_fifo
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  alu_cmd_t                 i_cmd,
    input  logic                     i_pop,
    output alu_cmd_t                 o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    alu_cmd_t               r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_level;

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/alu4_issue_queue.sv
// -----------------------------------------------------------------------------
// alu4_issue_queue
// Issue stage in front of the external combinational 4-bit ALU. Commands are
// buffered in a FIFO, the FIFO head drives the ALU, and the ALU result is
// captured into a valid/ready output register.
// Optional feature macro: ALU_ISSUE_FLAGS_EN adds registered out_zero/out_carry.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  command handshake (in_ready = !full)
//   in_operand_A/B, in_operation       command payload
//   alu_operand_A/B, alu_operation     FIFO head to ALU (0 when empty)
//   alu_result                         ALU result (combinational from alu_*)
//   out_valid/out_ready                result handshake
//   out_result, out_operation          registered result and its operation
//   out_zero, out_carry                registered flags (ALU_ISSUE_FLAGS_EN)
//   level                              FIFO occupancy
// -----------------------------------------------------------------------------
module alu4_issue_queue
    import alu4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_operand_A,
    input  logic [DATA_W-1:0]       in_operand_B,
    input  logic [1:0]              in_operation,
    output logic [DATA_W-1:0]       alu_operand_A,
    output logic [DATA_W-1:0]       alu_operand_B,
    output logic [1:0]              alu_operation,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_result,
    output logic [1:0]              out_operation,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic                    out_zero,
    output logic                    out_carry,
`endif
    output logic [$clog2(DEPTH):0]  level
);

    alu_cmd_t           w_in_cmd;
    alu_cmd_t           w_head;
    alu_cmd_t           w_alu_cmd;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_result;
    logic [1:0]         r_out_operation;

    assign w_in_cmd = '{operand_A: in_operand_A,
                        operand_B: in_operand_B,
                        operation: alu_op_t'(in_operation)};

    // in_ready depends only on occupancy, never on a same-cycle pop.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && (!r_out_valid || out_ready);

    alu4_cmd_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_cmd   (w_in_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Stale storage is never shown to the ALU: an empty queue drives zeros.
    assign w_alu_cmd     = w_empty ? '0 : w_head;
    assign alu_operand_A = w_alu_cmd.operand_A;
    assign alu_operand_B = w_alu_cmd.operand_B;
    assign alu_operation = w_alu_cmd.operation;

`ifdef ALU_ISSUE_FLAGS_EN
    logic [DATA_W:0]    w_sum;
    logic               w_carry;
    logic               w_zero;
    logic               r_out_zero;
    logic               r_out_carry;

    assign w_sum  = {1'b0, w_alu_cmd.operand_A} + {1'b0, w_alu_cmd.operand_B};
    assign w_zero = (alu_result == '0);

    always_comb begin
        w_carry = 1'b0;
        case (w_alu_cmd.operation)
            ALU_ADD: w_carry = w_sum[DATA_W];
            ALU_SUB: w_carry = (w_alu_cmd.operand_A < w_alu_cmd.operand_B);
            default: w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_zero  <= 1'b0;
            r_out_carry <= 1'b0;
        end else if (w_pop) begin
            r_out_zero  <= w_zero;
            r_out_carry <= w_carry;
        end
    end

    assign out_zero  = r_out_zero;
    assign out_carry = r_out_carry;
`endif

    // Output register: loads on pop, clears when drained with nothing behind it,
    // otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_result    <= '0;
            r_out_operation <= '0;
        end else if (w_pop) begin
            r_out_valid     <= 1'b1;
            r_out_result    <= alu_result;
            r_out_operation <= w_alu_cmd.operation;
        end else if (out_ready) begin
            r_out_valid     <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_operation = r_out_operation;

endmodule
